// File: rtl/spi_reg_mode.sv
// spi_reg_mode: SPI-slave register port with per-frame CPOL/CPHA, REG_W-bit words, auto-increment bursts.
// Latency: pins act SYNC_STAGES+1 clk after arrival; miso moves 1 clk after change edge; read strobe same clk, write strobe 1 clk after last sample edge.
// Backpressure: none; register file must take write strobes immediately and drive reg_data_i combinationally while reg_rd_vld is high.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   sclk, nss, mosi   asynchronous SPI pins (nss active low); miso is the MSB of the output shift register
//   cpol, cpha        SPI mode, latched on the nss falling edge
//   status            byte returned on miso during the command byte
//   reg_addr          current register address (auto-increments, wraps modulo 2^ADDR_W)
//   reg_data_i        read data for reg_addr, captured while reg_rd_vld is high
//   reg_rd_vld        read strobe (1 cycle)
//   reg_data_o        write data; reg_data_o_vld is its 1-cycle strobe
//   fastcmd           low 6 bits of a fast command; fastcmd_vld is its 1-cycle strobe
//   frame_err         1-cycle pulse when nss rises in the middle of a byte or word
module spi_reg_mode #(
   parameter int ADDR_W      = 3,
   parameter int REG_W       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sclk,
   input  logic              nss,
   input  logic              mosi,
   output logic              miso,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [7:0]        status,
   output logic [ADDR_W-1:0] reg_addr,
   input  logic [REG_W-1:0]  reg_data_i,
   output logic              reg_rd_vld,
   output logic [REG_W-1:0]  reg_data_o,
   output logic              reg_data_o_vld,
   output logic [5:0]        fastcmd,
   output logic              fastcmd_vld,
   output logic              frame_err
);

   typedef enum logic [1:0] {WAIT_DESEL, IDLE, CMD, DATA} state_t;

   // Bit counter holds the number of sample edges seen in the current byte/word.
   localparam logic [5:0] CMD_LAST  = 6'd7;
   localparam logic [5:0] WORD_LAST = 6'(REG_W - 1);

   // ------------------------------------------------------------------
   // Pin synchronisers and edge detection
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] sclk_sq, nss_sq, mosi_sq;
   logic                   sclk_dly_q, nss_dly_q;
   logic                   sclk_s, nss_s, mosi_s;
   logic                   sclk_rise, sclk_fall, nss_rise, nss_fall;
   logic                   smp_edge, chg_edge;

   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sq    <= '0;
         nss_sq     <= '0;
         mosi_sq    <= '0;
         sclk_dly_q <= 1'b0;
         nss_dly_q  <= 1'b0;
      end else begin
         sclk_sq    <= {sclk_sq[SYNC_STAGES-2:0], sclk};
         nss_sq     <= {nss_sq[SYNC_STAGES-2:0], nss};
         mosi_sq    <= {mosi_sq[SYNC_STAGES-2:0], mosi};
         sclk_dly_q <= sclk_sq[SYNC_STAGES-1];
         nss_dly_q  <= nss_sq[SYNC_STAGES-1];
      end
   end

   assign sclk_s    = sclk_sq[SYNC_STAGES-1];
   assign nss_s     = nss_sq[SYNC_STAGES-1];
   assign mosi_s    = mosi_sq[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_dly_q;
   assign sclk_fall = ~sclk_s & sclk_dly_q;
   assign nss_rise  = nss_s & ~nss_dly_q;
   assign nss_fall  = ~nss_s & nss_dly_q;

   // Modes 0 and 3 sample on the rising edge, modes 1 and 2 on the falling edge.
   logic cpol_q, cpol_d, cpha_q, cpha_d;
   assign smp_edge = (cpol_q == cpha_q) ? sclk_rise : sclk_fall;
   assign chg_edge = (cpol_q == cpha_q) ? sclk_fall : sclk_rise;

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   state_t              state_q, state_d;
   logic [5:0]          cnt_q, cnt_d;
   logic [REG_W-2:0]    isr_q, isr_d;        // input shift register (MSB drops off when a word completes)
   logic [REG_W-1:0]    osr_q, osr_d;        // output shift register, MSB drives miso
   logic [REG_W-1:0]    rd_buf_q, rd_buf_d;  // prefetched read word waiting for the next boundary
   logic                shift_pend_q, shift_pend_d;
   logic                is_rd_q, is_rd_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [REG_W-1:0]    wdat_q, wdat_d;
   logic                wvld_q, wvld_d;
   logic [5:0]          fcmd_q, fcmd_d;
   logic                fvld_q, fvld_d;
   logic                ferr_q, ferr_d;

   // Combinational decode helpers
   logic [REG_W-1:0]    isr_shift;
   logic [7:0]          cmd_byte;
   logic [ADDR_W-1:0]   cmd_addr;
   logic                rd_pulse;
   logic                cmd_rd;

   always_comb begin
      state_d      = state_q;
      cpol_d       = cpol_q;
      cpha_d       = cpha_q;
      cnt_d        = cnt_q;
      isr_d        = isr_q;
      osr_d        = osr_q;
      rd_buf_d     = rd_buf_q;
      shift_pend_d = shift_pend_q;
      is_rd_d      = is_rd_q;
      addr_d       = addr_q;
      wdat_d       = wdat_q;
      fcmd_d       = fcmd_q;
      wvld_d       = 1'b0;
      fvld_d       = 1'b0;
      ferr_d       = 1'b0;
      rd_pulse     = 1'b0;
      cmd_rd       = 1'b0;

      isr_shift = {isr_q, mosi_s};
      cmd_byte  = isr_shift[7:0];
      cmd_addr  = cmd_byte[ADDR_W-1:0];

      // Write address advances the cycle after the write strobe.
      if (wvld_q) begin
         addr_d = addr_q + ADDR_W'(1);
      end

      // Output side: one shift per sample edge, applied on the following
      // change edge. A zero counter means a byte/word just completed, so the
      // next word is loaded instead. This runs in every state so the pending
      // reload after a fast/reserved command still flushes miso to zero.
      if (chg_edge && shift_pend_q) begin
         shift_pend_d = 1'b0;
         if (cnt_q == '0) begin
            osr_d = rd_buf_q;
         end else begin
            osr_d = {osr_q[REG_W-2:0], 1'b0};
         end
      end

      unique case (state_q)
         WAIT_DESEL: begin
            if (nss_s) begin
               state_d = IDLE;
            end
         end

         IDLE: begin
            if (nss_fall) begin
               state_d      = CMD;
               cpol_d       = cpol;
               cpha_d       = cpha;
               cnt_d        = '0;
               isr_d        = '0;
               osr_d        = '0;
               osr_d[REG_W-1 -: 8] = status;
               rd_buf_d     = '0;
               shift_pend_d = 1'b0;
            end
         end

         CMD, DATA: begin
            if (smp_edge) begin
               isr_d        = isr_shift[REG_W-2:0];
               shift_pend_d = 1'b1;
               if (cnt_q == ((state_q == CMD) ? CMD_LAST : WORD_LAST)) begin
                  cnt_d = '0;
                  if (state_q == CMD) begin
                     unique case (cmd_byte[7:6])
                        2'b00: begin
                           // First read: the strobe uses the decoded address
                           // this cycle, the register then holds address+1.
                           cmd_rd   = 1'b1;
                           rd_pulse = 1'b1;
                           rd_buf_d = reg_data_i;
                           addr_d   = cmd_addr + ADDR_W'(1);
                           is_rd_d  = 1'b1;
                           state_d  = DATA;
                        end
                        2'b10: begin
                           addr_d  = cmd_addr;
                           is_rd_d = 1'b0;
                           state_d = DATA;
                        end
                        2'b11: begin
                           fcmd_d  = cmd_byte[5:0];
                           fvld_d  = 1'b1;
                           state_d = WAIT_DESEL;
                        end
                        default: begin
                           state_d = WAIT_DESEL;
                        end
                     endcase
                  end else if (is_rd_q) begin
                     // Prefetch next word; also happens after the final word.
                     rd_pulse = 1'b1;
                     rd_buf_d = reg_data_i;
                     addr_d   = addr_q + ADDR_W'(1);
                  end else begin
                     wdat_d = isr_shift;
                     wvld_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 6'd1;
               end
            end

            // Counter is judged after this cycle's sample edge, so a word that
            // completes together with the nss rise is committed, not aborted.
            if (nss_rise) begin
               ferr_d  = (cnt_d != '0);
               state_d = IDLE;
            end
         end

         default: begin
            state_d = WAIT_DESEL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= WAIT_DESEL;
         cpol_q       <= 1'b0;
         cpha_q       <= 1'b0;
         cnt_q        <= '0;
         isr_q        <= '0;
         osr_q        <= '0;
         rd_buf_q     <= '0;
         shift_pend_q <= 1'b0;
         is_rd_q      <= 1'b0;
         addr_q       <= '0;
         wdat_q       <= '0;
         wvld_q       <= 1'b0;
         fcmd_q       <= '0;
         fvld_q       <= 1'b0;
         ferr_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cpol_q       <= cpol_d;
         cpha_q       <= cpha_d;
         cnt_q        <= cnt_d;
         isr_q        <= isr_d;
         osr_q        <= osr_d;
         rd_buf_q     <= rd_buf_d;
         shift_pend_q <= shift_pend_d;
         is_rd_q      <= is_rd_d;
         addr_q       <= addr_d;
         wdat_q       <= wdat_d;
         wvld_q       <= wvld_d;
         fcmd_q       <= fcmd_d;
         fvld_q       <= fvld_d;
         ferr_q       <= ferr_d;
      end
   end

   // Read strobe is combinational so reg_data_i is sampled in the very cycle
   // the last sample edge is detected; it is held off while in reset.
   assign reg_rd_vld     = rd_pulse & ~rst;
   assign reg_addr       = (cmd_rd && !rst) ? cmd_addr : addr_q;
   assign miso           = osr_q[REG_W-1];
   assign reg_data_o     = wdat_q;
   assign reg_data_o_vld = wvld_q;
   assign fastcmd        = fcmd_q;
   assign fastcmd_vld    = fvld_q;
   assign frame_err      = ferr_q;

endmodule

// File: tb/tb_spi_reg_mode.sv
// tb_spi_reg_mode: directed SPI master frames with a scoreboard model of the register port.
// Latency: checks pulses on every clock, frame results after each frame ends.
// Backpressure: none; the bench register file answers reads combinationally.
module tb_spi_reg_mode;
   localparam int ADDR_W      = 3;
   localparam int REG_W       = 16;
   localparam int SYNC_STAGES = 2;
   localparam int HALF        = 8;   // sclk half period in clk cycles

   logic              clk = 1'b0;
   logic              rst;
   logic              sclk, nss, mosi, miso, cpol, cpha;
   logic [7:0]        status;
   logic [ADDR_W-1:0] reg_addr;
   logic [REG_W-1:0]  reg_data_i, reg_data_o;
   logic              reg_rd_vld, reg_data_o_vld;
   logic [5:0]        fastcmd;
   logic              fastcmd_vld, frame_err;

   always #5 clk = ~clk;

   spi_reg_mode #(.ADDR_W(ADDR_W), .REG_W(REG_W), .SYNC_STAGES(SYNC_STAGES)) dut (
      .clk(clk), .rst(rst), .sclk(sclk), .nss(nss), .mosi(mosi), .miso(miso),
      .cpol(cpol), .cpha(cpha), .status(status), .reg_addr(reg_addr),
      .reg_data_i(reg_data_i), .reg_rd_vld(reg_rd_vld), .reg_data_o(reg_data_o),
      .reg_data_o_vld(reg_data_o_vld), .fastcmd(fastcmd), .fastcmd_vld(fastcmd_vld),
      .frame_err(frame_err)
   );

   logic [15:0] regs [8];
   assign reg_data_i = regs[reg_addr];

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- model / scoreboard ----------------
   logic [2:0]  exp_rd_q[$];
   logic [18:0] exp_wr_q[$];   // {addr, data}
   logic [5:0]  exp_fc_q[$];
   logic [18:0] wr_log[$];
   int          err_seen = 0;
   int          exp_err  = 0;
   logic [2:0]  model_addr = 3'd0;

   // ---------------- compare process ----------------
   logic       prev_rd = 1'b0, prev_wr = 1'b0, prev_fc = 1'b0, prev_err = 1'b0;
   logic       addr_step = 1'b0;
   logic [2:0] step_from = 3'd0;
   logic [2:0] step_to;

   always @(negedge clk) begin
      if (rst) begin
         prev_rd = 1'b0; prev_wr = 1'b0; prev_fc = 1'b0; prev_err = 1'b0;
         addr_step = 1'b0;
      end else begin
         if (addr_step) begin
            step_to = step_from + 3'd1;
            chk("addr_incr", reg_addr, step_to);
         end
         addr_step = 1'b0;
         if (reg_rd_vld) begin
            chk("rd_pulse_len", prev_rd, 0);
            chk("rd_expected", exp_rd_q.size() != 0, 1);
            if (exp_rd_q.size() != 0) chk("rd_addr", reg_addr, exp_rd_q.pop_front());
            addr_step = 1'b1;
            step_from = reg_addr;
         end
         if (reg_data_o_vld) begin
            chk("wr_pulse_len", prev_wr, 0);
            chk("wr_expected", exp_wr_q.size() != 0, 1);
            if (exp_wr_q.size() != 0) chk("wr_addr_data", {reg_addr, reg_data_o}, exp_wr_q.pop_front());
            wr_log.push_back({reg_addr, reg_data_o});
            addr_step = 1'b1;
            step_from = reg_addr;
         end
         if (fastcmd_vld) begin
            chk("fc_pulse_len", prev_fc, 0);
            chk("fc_expected", exp_fc_q.size() != 0, 1);
            if (exp_fc_q.size() != 0) chk("fastcmd", fastcmd, exp_fc_q.pop_front());
         end
         if (frame_err) begin
            chk("err_pulse_len", prev_err, 0);
            err_seen++;
         end
         prev_rd = reg_rd_vld; prev_wr = reg_data_o_vld;
         prev_fc = fastcmd_vld; prev_err = frame_err;
      end
   end

   // ---------------- SPI master ----------------
   logic        m_pha;
   logic [15:0] tx_w [4];
   logic [15:0] rx_w [4];
   logic [7:0]  rx_st;

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic spi_bits(input logic [15:0] tx, input int n, output logic [15:0] rx);
      rx = '0;
      for (int i = n - 1; i >= 0; i--) begin
         if (!m_pha) begin
            mosi = tx[i];
            wait_clk(HALF);
            sclk = ~sclk;            // sample edge
            rx[i] = miso;
            wait_clk(HALF);
            sclk = ~sclk;            // change edge
         end else begin
            sclk = ~sclk;            // change edge
            mosi = tx[i];
            wait_clk(HALF);
            sclk = ~sclk;            // sample edge
            rx[i] = miso;
            wait_clk(HALF);
         end
      end
   endtask

   task automatic frame_begin(input logic pol, input logic pha);
      m_pha = pha;
      cpol  = pol;
      cpha  = pha;
      sclk  = pol;
      wait_clk(HALF);
      nss = 1'b0;
      wait_clk(HALF);
   endtask

   task automatic frame_end();
      wait_clk(HALF);
      nss = 1'b1;
      wait_clk(4 * HALF);
   endtask

   // One frame: the model records what the port must do, the master drives
   // the pins, then received data and end-of-frame state are compared.
   task automatic do_frame(input string tag, input logic pol, input logic pha,
                           input logic [7:0] cmd, input int nwords, input int wbits,
                           input int abort_bits);
      logic [2:0]  a, idx;
      logic [15:0] rx, exp_w;
      a = cmd[2:0];
      case (cmd[7:6])
         2'b00: begin
            for (int k = 0; k <= nwords; k++) exp_rd_q.push_back(a + 3'(k));
            model_addr = a + 3'(nwords + 1);
         end
         2'b10: begin
            for (int k = 0; k < nwords; k++) exp_wr_q.push_back({a + 3'(k), tx_w[k]});
            model_addr = a + 3'(nwords);
            if (abort_bits > 0) exp_err++;
         end
         2'b11: exp_fc_q.push_back(cmd[5:0]);
         default: ;
      endcase

      frame_begin(pol, pha);
      spi_bits({8'h00, cmd}, 8, rx);
      rx_st = rx[7:0];
      for (int k = 0; k < nwords; k++) begin
         spi_bits(tx_w[k], wbits, rx);
         rx_w[k] = rx;
      end
      if (abort_bits > 0) spi_bits(tx_w[nwords] >> (wbits - abort_bits), abort_bits, rx);
      frame_end();

      chk({tag, ":status_byte"}, rx_st, status);
      for (int k = 0; k < nwords; k++) begin
         idx   = a + 3'(k);
         exp_w = (cmd[7:6] == 2'b00) ? regs[idx] : 16'h0000;
         chk({tag, ":rx_word"}, rx_w[k], exp_w);
      end
      chk({tag, ":reg_addr"}, reg_addr, model_addr);
      chk({tag, ":rd_left"}, exp_rd_q.size(), 0);
      chk({tag, ":wr_left"}, exp_wr_q.size(), 0);
      chk({tag, ":fc_left"}, exp_fc_q.size(), 0);
      chk({tag, ":frame_err_cnt"}, err_seen, exp_err);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [15:0] rx;
      logic [1:0]  md;
      rst = 1'b1; sclk = 1'b0; nss = 1'b1; mosi = 1'b0;
      cpol = 1'b0; cpha = 1'b0; m_pha = 1'b0; status = 8'hA5;
      for (int i = 0; i < 8; i++) regs[i] = 16'h1111 * 16'(i);
      regs[2] = 16'h5A3C;
      regs[3] = 16'hC3E1;
      wait_clk(5);
      chk("rst_miso", miso, 0);
      chk("rst_reg_addr", reg_addr, 0);
      chk("rst_rd_vld", reg_rd_vld, 0);
      chk("rst_wr_vld", reg_data_o_vld, 0);
      chk("rst_reg_data_o", reg_data_o, 0);
      chk("rst_fastcmd", fastcmd, 0);
      chk("rst_fc_vld", fastcmd_vld, 0);
      chk("rst_frame_err", frame_err, 0);
      rst = 1'b0;
      wait_clk(10);

      // Mode 0 write burst with address wrap 7 -> 0
      tx_w[0] = 16'hBEEF; tx_w[1] = 16'h1234;
      do_frame("wr_burst", 1'b0, 1'b0, 8'h86, 2, 16, 0);
      chk("wr_burst_count", wr_log.size(), 2);
      if (wr_log.size() >= 2) begin
         chk("wr_burst_w0_lit", wr_log[0], {3'd6, 16'hBEEF});
         chk("wr_burst_w1_lit", wr_log[1], {3'd7, 16'h1234});
      end
      chk("wr_burst_wrap_lit", reg_addr, 3'd0);

      // Read register 2 in all four modes
      for (int m = 0; m < 4; m++) begin
         md = 2'(m);
         do_frame($sformatf("rd_mode%0d", m), md[1], md[0], 8'h02, 1, 16, 0);
         chk($sformatf("rd_mode%0d_status_lit", m), rx_st, 8'hA5);
         chk($sformatf("rd_mode%0d_data_lit", m), rx_w[0], 16'h5A3C);
         chk($sformatf("rd_mode%0d_addr_lit", m), reg_addr, 3'd4);
      end

      // Fast command plus 8 idle clocks
      do_frame("fast", 1'b0, 1'b0, 8'hC5, 1, 8, 0);
      chk("fast_code_lit", fastcmd, 6'h05);

      // Aborted write after 3 bits, then a good write to the same address
      tx_w[0] = 16'hBEEF;
      do_frame("abort", 1'b0, 1'b0, 8'h81, 0, 16, 3);
      chk("abort_err_lit", err_seen, 1);
      do_frame("wr_after_abort", 1'b1, 1'b1, 8'h81, 1, 16, 0);
      if (wr_log.size() >= 3) chk("wr_after_abort_lit", wr_log[wr_log.size() - 1], {3'd1, 16'hBEEF});
      chk("wr_after_abort_addr_lit", reg_addr, 3'd2);

      // Reset in the middle of a data word with nss held low
      frame_begin(1'b0, 1'b0);
      spi_bits(16'h0084, 8, rx);
      spi_bits(16'h001F, 5, rx);
      rst = 1'b1;
      wait_clk(3);
      chk("midrst_miso", miso, 0);
      chk("midrst_reg_addr", reg_addr, 0);
      chk("midrst_wr_vld", reg_data_o_vld, 0);
      chk("midrst_rd_vld", reg_rd_vld, 0);
      chk("midrst_frame_err", frame_err, 0);
      rst = 1'b0;
      model_addr = 3'd0;
      spi_bits(16'h07FF, 11, rx);
      spi_bits(16'hFFFF, 16, rx);
      frame_end();
      chk("postrst_reg_addr", reg_addr, model_addr);
      chk("postrst_err_cnt", err_seen, exp_err);
      do_frame("rd_after_rst", 1'b0, 1'b0, 8'h02, 1, 16, 0);

      // Reserved op: no strobes, address untouched
      tx_w[0] = 16'hFFFF;
      do_frame("reserved", 1'b0, 1'b1, 8'h43, 1, 16, 0);
      chk("reserved_addr_lit", reg_addr, 3'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
